// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and types for the 8-way round-robin arbiter.
// Revision    : 1.0
// ============================================================================
package arb_pkg;

    localparam int NREQ   = 8;
    localparam int IDXW   = 3;
    localparam int BEAT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Round-robin pick: first set request at or after ptr, mod 8.
// Revision    : 1.0
// ============================================================================
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] idx
);

    logic [NREQ-1:0] w_rot;
    logic [IDXW-1:0] w_off;

    // Rotate so ptr lands on bit 0, find the lowest set bit, rotate back.
    always_comb begin
        w_rot = '0;
        w_off = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[IDXW'(i) + ptr];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDXW'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + w_off;

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arb8_idx.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb8_idx
// Description : 8-way round-robin arbiter with burst lock, watchdog release
//               and a registered 3-bit grant index.
// Revision    : 1.0
// ============================================================================
module rr_arb8_idx #(
    parameter int NREQ      = arb_pkg::NREQ,
    parameter int IDXW      = arb_pkg::IDXW,
    parameter int MAX_BEATS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_last,
    input  logic            gnt_ready,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_forced
);

    import arb_pkg::*;

    arb_state_t        r_state;
    logic [IDXW-1:0]   r_ptr;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic [IDXW-1:0]   w_next_ptr;
    logic [IDXW-1:0]   w_pick_ptr;
    logic [IDXW-1:0]   w_pick_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_last;
    logic              w_wdog;
    logic              w_end;

    assign w_next_ptr = gnt_idx + IDXW'(1);
    // While busy the only pick that matters is the back-to-back regrant.
    assign w_pick_ptr = (r_state == BUSY) ? w_next_ptr : r_ptr;
    assign w_accept   = gnt_valid & gnt_ready;
    assign w_last     = req_last[gnt_idx];
    assign w_wdog     = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign w_end      = w_accept & (w_last | w_wdog);

    rr_pick8 u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .any (w_any),
        .idx (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_forced <= 1'b0;
        end else begin
            gnt_forced <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    gnt_idx    <= w_pick_idx;
                    gnt_valid  <= 1'b1;
                    r_beat_cnt <= '0;
                    r_state    <= BUSY;
                end
            end else begin
                if (w_end) begin
                    r_ptr      <= w_next_ptr;
                    gnt_forced <= ~w_last;
                    r_beat_cnt <= '0;
                    if (w_any) begin
                        gnt_idx <= w_pick_idx;
                    end else begin
                        gnt_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end else if (w_accept) begin
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

endmodule : rr_arb8_idx
`default_nettype wire

// File: tb/tb_rr_arb8_idx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb8_idx
// Description : Directed + random self-checking bench for rr_arb8_idx.
// Revision    : 1.0
// ============================================================================
module tb_rr_arb8_idx;

    localparam int C_MAXB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] req_last;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       gnt_forced;

    int checks   = 0;
    int failures = 0;

    // Reference state: whether a burst is open, who owns it, beats taken so far.
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_beats;
    bit m_forced;

    rr_arb8_idx #(
        .NREQ      (8),
        .IDXW      (3),
        .MAX_BEATS (C_MAXB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_last   (req_last),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_forced (gnt_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, m_valid});
        if (m_valid) chk({tag, ".idx"}, {5'd0, gnt_idx}, 8'(m_idx));
        chk({tag, ".forced"}, {7'd0, gnt_forced}, {7'd0, m_forced});
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_idx    = 0;
        m_ptr    = 0;
        m_beats  = 0;
        m_forced = 1'b0;
    endtask

    // One clock: advance the reference from the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        m_forced = 1'b0;
        if (!m_valid) begin
            if (req != 8'h00) begin
                m_idx   = pick(req, m_ptr);
                m_valid = 1'b1;
                m_beats = 0;
            end
        end else if (gnt_ready) begin
            m_beats++;
            if (req_last[m_idx] || m_beats == C_MAXB) begin
                m_forced = !req_last[m_idx];
                m_ptr    = (m_idx + 1) % 8;
                m_beats  = 0;
                if (req != 8'h00) m_idx = pick(req, m_ptr);
                else m_valid = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rdy);
        @(negedge clk);
        req       = r;
        req_last  = l;
        gnt_ready = rdy;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 8'h00;
        req_last  = 8'h00;
        gnt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester, one-beat burst, then idle.
        drive(8'h01, 8'hFF, 1'b0); step("single_grant");
        drive(8'h00, 8'hFF, 1'b1); step("single_release");
        step("single_idle");

        // Everyone requesting, every beat last: strict rotation, no bubbles.
        drive(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) step("fair");
        drive(8'h00, 8'hFF, 1'b1); step("fair_drain");
        step("fair_idle");

        // Grant 2, release to idle (ptr=3), then 0 and 2 contend.
        drive(8'h04, 8'hFF, 1'b0); step("wrap_g2");
        drive(8'h00, 8'hFF, 1'b1); step("wrap_rel2");
        drive(8'h05, 8'hFF, 1'b0); step("wrap_g0");
        drive(8'h05, 8'hFF, 1'b1); step("wrap_g2b");
        drive(8'h00, 8'hFF, 1'b1); step("wrap_drain");

        // Backpressure on requester 5 while req toggles.
        drive(8'h20, 8'h00, 1'b0); step("bp_grant");
        for (int i = 0; i < 6; i++) begin
            drive(8'($urandom), 8'h00, 1'b0);
            step("bp_hold");
        end
        drive(8'h00, 8'h20, 1'b1); step("bp_release");
        step("bp_idle");

        // Watchdog: requester 3 never signals last.
        drive(8'h08, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) step("wdog");
        drive(8'h00, 8'h00, 1'b0); step("wdog_stop");
        drive(8'h00, 8'hFF, 1'b1); step("wdog_drain");
        step("wdog_idle");

        // Async reset mid-burst, then the first grant follows reset priority.
        drive(8'h88, 8'h00, 1'b1); step("rst_grant");
        step("rst_beat");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        drive(8'h88, 8'h00, 1'b0); step("rst_first");
        drive(8'h00, 8'hFF, 1'b1); step("rst_drain");

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            drive(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  1'($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arb8_idx
`default_nettype wire
